uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 153 +++++++++++++++
 tb/tb_uart_tx_feeder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one byte at a time.
//
// Ports:
//   clk      - single clock for all logic
//   srst_n   - asynchronous active-low reset
//   wr_en    - host write request
//   wr_data  - byte to enqueue
//   full     - FIFO holds DEPTH entries
//   empty    - FIFO holds no entries
//   count    - current occupancy
//   tx_start - level request to the transmitter, held until tx_done
//   tx_data  - byte presented to the transmitter, changes only on a pop
//   tx_done  - transmitter end-of-transmission level
//   ovf_clr  - clears the overflow flag
//   overflow - sticky flag set when a write is dropped
//
// Optional feature: define UART_TX_FEEDER_OVF_EN to enable the overflow flag.
// Without it, overflow is tied to 0 and ovf_clr is ignored.
//
// DEPTH must be a power of two in 4..256 so the pointers wrap naturally.

module uart_tx_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         srst_n,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_done,
  input  logic                         ovf_clr,
  output logic                         overflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StSend, StRelease} state_e;

  state_e              state_q;
  logic [AddrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic                tx_start_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic pop, push;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // Only IDLE pops, so at most one byte is ever in flight.
  assign pop  = (state_q == StIdle) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = wr_en && (!full || pop);

  // Storage is not reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Handshake FSM with registered tx_start/tx_data.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q    <= StIdle;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            tx_data_q  <= mem[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (tx_done) begin
            tx_start_q <= 1'b0;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          // Wait for tx_done to drop so a long done level is not seen twice.
          if (!tx_done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

`ifdef UART_TX_FEEDER_OVF_EN
  logic overflow_q;
  logic drop;

  assign drop = wr_en && full && !pop;

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DATA_W = 8;

`ifdef UART_TX_FEEDER_OVF_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic              clk;
  logic              srst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [4:0]        count;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              ovf_clr;
  logic              overflow;

  int tests = 0;
  int fails = 0;

  // Bytes observed at each rising tx_start.
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  int         n_starts = 0;
  logic       start_seen = 1'b0;

  uart_tx_feeder #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .srst_n   (srst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start && !start_seen) begin
      log_q.push_back(tx_data);
      n_starts++;
    end
    start_seen = tx_start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Acts as the transmitter for one byte: wait for tx_start, hold done 2 cycles.
  task automatic serve_one();
    int t = 0;
    while (tx_start !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    check("serve_wait", {31'b0, tx_start}, 32'd1);
    tx_done = 1'b1;
    step();
    step();
    tx_done = 1'b0;
    step();
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check(tag, {24'b0, log_q[i]}, {24'b0, exp_q[i]});
    end
  endtask

  initial begin
    srst_n  = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_done = 1'b0;
    ovf_clr = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 srst_n = 1'b0;
    #1;
    check("rst_empty",    {31'b0, empty},    32'd1);
    check("rst_full",     {31'b0, full},     32'd0);
    check("rst_count",    {27'b0, count},    32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data",  {24'b0, tx_data},  32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    step();
    step();
    srst_n = 1'b1;
    step();

    // Single byte, one-cycle start latency, 3-cycle done level.
    log_q.delete();
    n_starts = 0;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("a5_count_after_wr", {27'b0, count},    32'd1);
    check("a5_start_early",    {31'b0, tx_start}, 32'd0);
    step();
    check("a5_tx_start", {31'b0, tx_start}, 32'd1);
    check("a5_tx_data",  {24'b0, tx_data},  32'hA5);
    check("a5_count",    {27'b0, count},    32'd0);
    check("a5_empty",    {31'b0, empty},    32'd1);
    tx_done = 1'b1;
    step();
    check("a5_start_clr", {31'b0, tx_start}, 32'd0);
    step();
    step();
    tx_done = 1'b0;
    check("a5_release", {31'b0, tx_start}, 32'd0);
    step();
    // tx_done in IDLE must not start anything.
    tx_done = 1'b1;
    step();
    step();
    tx_done = 1'b0;
    check("idle_done_start", {31'b0, tx_start}, 32'd0);
    check("idle_done_empty", {31'b0, empty},    32'd1);
    step();
    check("a5_starts", n_starts, 32'd1);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    check_log("a5_log");

    // Back-to-back writes while the transmitter is busy.
    log_q.delete();
    n_starts = 0;
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("b2b_count",    {27'b0, count},    32'd4);
    check("b2b_tx_start", {31'b0, tx_start}, 32'd1);
    check("b2b_tx_data",  {24'b0, tx_data},  32'h01);
    for (int i = 0; i < 5; i++) serve_one();
    for (int i = 0; i < 4; i++) step();
    check("b2b_empty",  {31'b0, empty},    32'd1);
    check("b2b_idle",   {31'b0, tx_start}, 32'd0);
    check("b2b_starts", n_starts, 32'd5);
    exp_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    check_log("b2b_log");

    // Fill to DEPTH with one byte in flight, then overflow.
    log_q.delete();
    n_starts = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      step();
    end
    check("fill_count",    {27'b0, count},    32'd16);
    check("fill_full",     {31'b0, full},     32'd1);
    check("fill_empty",    {31'b0, empty},    32'd0);
    check("fill_overflow", {31'b0, overflow}, 32'd0);
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    check("drop_count",    {27'b0, count},    32'd16);
    check("drop_overflow", {31'b0, overflow}, {31'b0, OvfEn});
    step();
    check("ovf_sticky", {31'b0, overflow}, {31'b0, OvfEn});
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'b0, overflow}, 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hEF;
    ovf_clr = 1'b1;
    step();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", {31'b0, overflow}, {31'b0, OvfEn});
    check("ovf_count",    {27'b0, count},    32'd16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared2", {31'b0, overflow}, 32'd0);

    // Finish the in-flight byte, then write on the pop edge of a full FIFO.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    check("full_idle_start", {31'b0, tx_start}, 32'd0);
    check("full_idle_full",  {31'b0, full},     32'd1);
    wr_en   = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    check("popwr_count",    {27'b0, count},    32'd16);
    check("popwr_full",     {31'b0, full},     32'd1);
    check("popwr_tx_start", {31'b0, tx_start}, 32'd1);
    check("popwr_tx_data",  {24'b0, tx_data},  32'h11);
    for (int i = 0; i < 17; i++) serve_one();
    step();
    check("popwr_empty", {31'b0, empty}, 32'd1);
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(8'(8'h10 + i));
    exp_q.push_back(8'h3C);
    check_log("popwr_log");

    // Reset in the middle of SEND with 4 bytes queued.
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h50 + i);
      step();
    end
    wr_en = 1'b0;
    check("mid_count",    {27'b0, count},    32'd4);
    check("mid_tx_start", {31'b0, tx_start}, 32'd1);
    #2 srst_n = 1'b0;
    #1;
    check("mid_rst_start", {31'b0, tx_start}, 32'd0);
    check("mid_rst_count", {27'b0, count},    32'd0);
    check("mid_rst_empty", {31'b0, empty},    32'd1);
    check("mid_rst_data",  {24'b0, tx_data},  32'd0);
    step();
    step();
    srst_n = 1'b1;
    log_q.delete();
    n_starts = 0;
    for (int i = 0; i < 6; i++) step();
    check("mid_no_start", n_starts, 32'd0);
    check("mid_idle",     {31'b0, tx_start}, 32'd0);

    // Stream 2*DEPTH+3 bytes in bursts so both pointers wrap twice.
    log_q.delete();
    n_starts = 0;
    exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 7; i++) begin
        wr_en   = 1'b1;
        wr_data = 8'(8'h80 + b * 7 + i);
        exp_q.push_back(8'(8'h80 + b * 7 + i));
        step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 7; i++) serve_one();
    end
    step();
    check("wrap_starts", n_starts, 32'd35);
    check("wrap_empty",  {31'b0, empty}, 32'd1);
    check_log("wrap_log");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
